// File: rtl/mine_count_engine_if.sv
// Signal bundle between the mine-count engine and the game/display logic.
// The master drives the start/map/query inputs; the engine (slave) drives the status and query results.
interface mine_count_engine_if #(
    parameter int CELLS = 25,
    parameter int IDX_W = 5,
    parameter int CNT_W = 4
);
    // Handshake: in_start is a level sampled only while the engine is idle.
    // out_busy is high from the capture edge until the final table write.
    // out_done pulses for the one cycle after that write.
    // Query results always appear one clock after in_query_idx is sampled.
    logic             in_start;
    logic [CELLS-1:0] in_mines;
    logic [IDX_W-1:0] in_query_idx;
    logic             out_busy;
    logic             out_done;
    logic             out_map_valid;
    logic [IDX_W-1:0] out_mine_total;
    logic             out_query_mine;
    logic [CNT_W-1:0] out_query_count;
    logic             out_query_err;
    logic [1:0]       dbg_state;

    modport master (
        output in_start, in_mines, in_query_idx,
        input  out_busy, out_done, out_map_valid, out_mine_total,
        input  out_query_mine, out_query_count, out_query_err, dbg_state
    );

    modport slave (
        input  in_start, in_mines, in_query_idx,
        output out_busy, out_done, out_map_valid, out_mine_total,
        output out_query_mine, out_query_count, out_query_err, dbg_state
    );
endinterface

// File: rtl/mine_count_engine.sv
// Builds the 5x5 adjacent-mine count table from a captured mine map, one cell per clock,
// and serves registered single-cell lookups. All state moves on the falling edge of in_clka.
module mine_count_engine #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int CELLS = ROWS * COLS,
    parameter int IDX_W = 5,
    parameter int CNT_W = 4
) (
    input logic                in_clka,
    input logic                in_reset_n,
    mine_count_engine_if.slave mc
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1
    } state_t;

    localparam logic [2:0]       LAST_ROW  = 3'(ROWS - 1);
    localparam logic [2:0]       LAST_COL  = 3'(COLS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] CELLS_IDX = IDX_W'(CELLS);

    state_t           state_q, state_d;
    logic             start_scan;
    logic             last_cell;

    logic [CELLS-1:0] mines_q;
    logic [31:0]      mines_ext;
    logic [CNT_W-1:0] count_mem [CELLS];
    logic [IDX_W-1:0] k_q;
    logic [2:0]       row_q;
    logic [2:0]       col_q;
    logic [IDX_W-1:0] total_q;
    logic             done_q;
    logic             valid_q;
    logic             q_mine_q;
    logic [CNT_W-1:0] q_count_q;
    logic             q_err_q;

    logic             has_up, has_dn, has_l, has_r;
    logic [7:0]       nbr_bits;
    logic [CNT_W-1:0] nbr_count;

    // FSM state register
    always_ff @(negedge in_clka) begin
        if (!in_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and scan control
    always_comb begin
        state_d    = state_q;
        start_scan = 1'b0;
        last_cell  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc.in_start) begin
                    start_scan = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (k_q == LAST_IDX) begin
                    last_cell = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-extended so k+6 on the last row never indexes past the vector; edge flags mask it anyway.
    assign mines_ext = 32'(mines_q);

    always_comb begin
        has_up      = (row_q != 3'd0);
        has_dn      = (row_q != LAST_ROW);
        has_l       = (col_q != 3'd0);
        has_r       = (col_q != LAST_COL);
        nbr_bits    = '0;
        nbr_bits[0] = has_up & has_l & mines_ext[k_q - IDX_W'(6)];
        nbr_bits[1] = has_up         & mines_ext[k_q - IDX_W'(5)];
        nbr_bits[2] = has_up & has_r & mines_ext[k_q - IDX_W'(4)];
        nbr_bits[3] = has_l          & mines_ext[k_q - IDX_W'(1)];
        nbr_bits[4] = has_r          & mines_ext[k_q + IDX_W'(1)];
        nbr_bits[5] = has_dn & has_l & mines_ext[k_q + IDX_W'(4)];
        nbr_bits[6] = has_dn         & mines_ext[k_q + IDX_W'(5)];
        nbr_bits[7] = has_dn & has_r & mines_ext[k_q + IDX_W'(6)];
        nbr_count   = '0;
        for (int i = 0; i < 8; i++) begin
            nbr_count = nbr_count + CNT_W'(nbr_bits[i]);
        end
    end

    // Scan datapath and registered query port
    always_ff @(negedge in_clka) begin
        if (!in_reset_n) begin
            mines_q   <= '0;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            total_q   <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            q_mine_q  <= 1'b0;
            q_count_q <= '0;
            q_err_q   <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                count_mem[i] <= '0;
            end
        end else begin
            done_q <= last_cell;

            if (start_scan) begin
                mines_q <= mc.in_mines;
                k_q     <= '0;
                row_q   <= '0;
                col_q   <= '0;
                total_q <= '0;
                valid_q <= 1'b0;
                // Stale entries from an earlier map must read 0 until rewritten.
                for (int i = 0; i < CELLS; i++) begin
                    count_mem[i] <= '0;
                end
            end else if (state_q == SCAN) begin
                count_mem[k_q] <= nbr_count;
                total_q        <= total_q + IDX_W'(mines_q[k_q]);
                k_q            <= k_q + IDX_W'(1);
                if (col_q == LAST_COL) begin
                    col_q <= 3'd0;
                    row_q <= row_q + 3'd1;
                end else begin
                    col_q <= col_q + 3'd1;
                end
                if (last_cell) begin
                    valid_q <= 1'b1;
                end
            end

            if (mc.in_query_idx >= CELLS_IDX) begin
                q_err_q   <= 1'b1;
                q_mine_q  <= 1'b0;
                q_count_q <= '0;
            end else begin
                q_err_q   <= 1'b0;
                q_mine_q  <= mines_q[mc.in_query_idx];
                q_count_q <= count_mem[mc.in_query_idx];
            end
        end
    end

    assign mc.out_busy        = (state_q == SCAN);
    assign mc.out_done        = done_q;
    assign mc.out_map_valid   = valid_q;
    assign mc.out_mine_total  = total_q;
    assign mc.out_query_mine  = q_mine_q;
    assign mc.out_query_count = q_count_q;
    assign mc.out_query_err   = q_err_q;
    assign mc.dbg_state       = state_q;
endmodule

// File: tb/tb_mine_count_engine.sv
// Directed bench for mine_count_engine: reset, single-mine maps, full board, ignored start,
// bad queries, mid-scan reset and back-to-back scans, all against hand-computed values.
module tb_mine_count_engine;
  logic in_clka;
  logic in_reset_n;
  int   vectors;
  int   miscompares;
  int   done_seen;
  logic flag;

  mine_count_engine_if mc ();

  mine_count_engine u_dut (
    .in_clka   (in_clka),
    .in_reset_n(in_reset_n),
    .mc        (mc)
  );

  // clock / reset
  initial begin
    in_clka = 1'b0;
    forever #5 in_clka = ~in_clka;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(negedge in_clka);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cell(input int idx, input int exp_mine, input int exp_cnt);
    mc.in_query_idx = 5'(idx);
    step();
    chk($sformatf("mine[%0d]", idx), 32'(mc.out_query_mine), 32'(exp_mine));
    chk($sformatf("count[%0d]", idx), 32'(mc.out_query_count), 32'(exp_cnt));
    chk($sformatf("err[%0d]", idx), 32'(mc.out_query_err), 32'd0);
  endtask

  // Starts a scan at edge E and checks done lands exactly after E+25 for one cycle.
  task automatic run_scan(input logic [24:0] map);
    logic early;
    mc.in_mines = map;
    mc.in_start = 1'b1;
    step();
    mc.in_start = 1'b0;
    chk("busy_after_start", 32'(mc.out_busy), 32'd1);
    chk("valid_after_start", 32'(mc.out_map_valid), 32'd0);
    early = 1'b0;
    repeat (24) begin
      step();
      if (mc.out_done !== 1'b0 || mc.out_busy !== 1'b1) early = 1'b1;
    end
    chk("done_early", 32'(early), 32'd0);
    step();
    chk("done_pulse", 32'(mc.out_done), 32'd1);
    chk("busy_end", 32'(mc.out_busy), 32'd0);
    chk("valid_end", 32'(mc.out_map_valid), 32'd1);
    step();
    chk("done_one_cycle", 32'(mc.out_done), 32'd0);
  endtask

  // stimulus and scoreboard
  initial begin
    vectors      = 0;
    miscompares  = 0;
    in_reset_n   = 1'b0;
    mc.in_start  = 1'b1;
    mc.in_mines  = 25'h1FFFFFF;
    mc.in_query_idx = 5'd30;

    // Reset held for 3 edges with start asserted
    repeat (3) step();
    chk("rst_busy", 32'(mc.out_busy), 32'd0);
    chk("rst_done", 32'(mc.out_done), 32'd0);
    chk("rst_valid", 32'(mc.out_map_valid), 32'd0);
    chk("rst_total", 32'(mc.out_mine_total), 32'd0);
    chk("rst_qmine", 32'(mc.out_query_mine), 32'd0);
    chk("rst_qcount", 32'(mc.out_query_count), 32'd0);
    chk("rst_qerr", 32'(mc.out_query_err), 32'd0);
    mc.in_start = 1'b0;
    in_reset_n  = 1'b1;
    mc.in_query_idx = 5'd0;
    step();
    chk("idle_state", 32'(mc.dbg_state), 32'd0);
    chk("idle_busy", 32'(mc.out_busy), 32'd0);
    chk("idle_valid", 32'(mc.out_map_valid), 32'd0);

    // Single corner mine at cell 0
    run_scan(25'h0000001);
    chk("corner_total", 32'(mc.out_mine_total), 32'd1);
    for (int i = 0; i < 25; i++)
      check_cell(i, (i == 0) ? 1 : 0, (i == 1 || i == 5 || i == 6) ? 1 : 0);

    // Centre mine at cell 12
    run_scan(25'h0001000);
    chk("centre_total", 32'(mc.out_mine_total), 32'd1);
    for (int i = 0; i < 25; i++)
      check_cell(i, (i == 12) ? 1 : 0,
                 (i == 6 || i == 7 || i == 8 || i == 11 || i == 13 ||
                  i == 16 || i == 17 || i == 18) ? 1 : 0);

    // Edge mine at cell 4: cell 5 must not see it across the row boundary
    run_scan(25'h0000010);
    for (int i = 0; i < 25; i++)
      check_cell(i, (i == 4) ? 1 : 0, (i == 3 || i == 8 || i == 9) ? 1 : 0);

    // Full board: corners 3, edges 5, interior 8
    run_scan(25'h1FFFFFF);
    chk("full_total", 32'(mc.out_mine_total), 32'd25);
    for (int i = 0; i < 25; i++) begin
      automatic bit er = (i / 5 == 0) || (i / 5 == 4);
      automatic bit ec = (i % 5 == 0) || (i % 5 == 4);
      check_cell(i, 1, (er && ec) ? 3 : ((er || ec) ? 5 : 8));
    end

    // Start while busy is ignored
    mc.in_mines = 25'h0000001;
    mc.in_start = 1'b1;
    step();
    mc.in_start = 1'b0;
    done_seen = 0;
    for (int j = 1; j <= 32; j++) begin
      if (j == 10) begin
        mc.in_start = 1'b1;
        mc.in_mines = 25'h1FFFFFF;
      end else begin
        mc.in_start = 1'b0;
      end
      step();
      if (mc.out_done === 1'b1) done_seen++;
    end
    mc.in_start = 1'b0;
    mc.in_mines = 25'h1FFFFFF;
    chk("busy_start_done_count", 32'(done_seen), 32'd1);
    chk("busy_start_total", 32'(mc.out_mine_total), 32'd1);
    check_cell(0, 1, 0);
    check_cell(1, 0, 1);
    check_cell(6, 0, 1);
    check_cell(12, 0, 0);

    // Out-of-range queries
    mc.in_query_idx = 5'd25;
    step();
    chk("err25", 32'(mc.out_query_err), 32'd1);
    chk("err25_count", 32'(mc.out_query_count), 32'd0);
    chk("err25_mine", 32'(mc.out_query_mine), 32'd0);
    mc.in_query_idx = 5'd31;
    step();
    chk("err31", 32'(mc.out_query_err), 32'd1);
    chk("err31_count", 32'(mc.out_query_count), 32'd0);
    check_cell(24, 0, 0);

    // Reset at E+12 aborts the scan
    mc.in_mines = 25'h1FFFFFF;
    mc.in_start = 1'b1;
    step();
    mc.in_start = 1'b0;
    repeat (11) step();
    in_reset_n = 1'b0;
    step();
    chk("abort_busy", 32'(mc.out_busy), 32'd0);
    chk("abort_done", 32'(mc.out_done), 32'd0);
    chk("abort_valid", 32'(mc.out_map_valid), 32'd0);
    chk("abort_total", 32'(mc.out_mine_total), 32'd0);
    in_reset_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      step();
      if (mc.out_done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    for (int i = 0; i < 25; i++) check_cell(i, 0, 0);

    // Back-to-back: new start accepted during the done cycle
    mc.in_mines = 25'h0001000;
    mc.in_start = 1'b1;
    step();
    mc.in_start = 1'b0;
    repeat (24) step();
    step();
    chk("b2b_first_done", 32'(mc.out_done), 32'd1);
    mc.in_mines = 25'h0000001;
    mc.in_start = 1'b1;
    mc.in_query_idx = 5'd7;
    step();
    mc.in_start = 1'b0;
    chk("b2b_busy", 32'(mc.out_busy), 32'd1);
    chk("b2b_valid_drop", 32'(mc.out_map_valid), 32'd0);
    chk("b2b_done_low", 32'(mc.out_done), 32'd0);
    step();
    chk("b2b_cleared_entry", 32'(mc.out_query_count), 32'd0);
    flag = 1'b0;
    repeat (23) begin
      step();
      if (mc.out_map_valid !== 1'b0 || mc.out_done !== 1'b0) flag = 1'b1;
    end
    chk("b2b_valid_held_low", 32'(flag), 32'd0);
    step();
    chk("b2b_second_done", 32'(mc.out_done), 32'd1);
    chk("b2b_valid", 32'(mc.out_map_valid), 32'd1);
    chk("b2b_total", 32'(mc.out_mine_total), 32'd1);
    check_cell(1, 0, 1);
    check_cell(7, 0, 0);
    check_cell(12, 0, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
